// File: rtl/pma_xlat.sv
// Physical-memory-address generator: picks the address source for each cache/memory
// cycle, then registers the address, its odd parity and the cycle type.
module pma_xlat #(
  parameter  int PAGE_W = 13,
  parameter  int OFF_W  = 9,
  parameter  int NCHAN  = 4,
  localparam int PA_W   = PAGE_W + OFF_W,
  localparam int CCA_W  = OFF_W - 2,
  localparam int SEL_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                  clk_pma_h,
  input  logic                  mr_reset_h,
  input  logic                  csh_ready_to_go_h,
  input  logic                  ebox_grant_h,
  input  logic [NCHAN-1:0]      chan_grant_h,
  input  logic                  cca_grant_h,
  input  logic                  wb_grant_h,
  input  logic                  cyc_done_h,
  input  logic                  hold_h,
  input  logic                  page_refill_h,
  input  logic                  ebox_paged_h,
  input  logic                  vma_user_h,
  input  logic                  load_ebr_h,
  input  logic                  load_ubr_h,
  input  logic [PAGE_W-1:0]     base_in,
  input  logic [PA_W-1:0]       vma_h,
  input  logic [PAGE_W-1:0]     pt_frame_h,
  input  logic [NCHAN*PA_W-1:0] ccw_adr_h,
  input  logic [PAGE_W-1:0]     cam_page_h,
  input  logic                  cca_all_pages_h,
  output logic [PA_W-1:0]       pa_h,
  output logic                  pa_par_h,
  output logic [2:0]            cyc_type_h,
  output logic [SEL_W-1:0]      chan_sel_h,
  output logic                  cca_cry_out_h,
  output logic                  grant_err_h
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EBOX   = 3'd1,
    ST_CHAN   = 3'd2,
    ST_CCA    = 3'd3,
    ST_WB     = 3'd4,
    ST_REFILL = 3'd5
  } state_t;

  localparam int GW = NCHAN + 3;

  state_t            state, state_nxt;
  logic [PA_W-1:0]   pa_nxt;
  logic [SEL_W-1:0]  chan_sel_nxt, chan_idx;
  logic [CCA_W-1:0]  cca_cnt, cca_cnt_nxt;
  logic              cry_nxt, err_nxt;
  logic [PAGE_W-1:0] ebr, ubr;
  logic [GW-1:0]     grants;
  logic              any_grant, multi_grant;
  logic [OFF_W-1:0]  vpage, refill_off;
  logic              unused_sink;

  // Sweep-all qualifier is consumed by the CAM logic downstream, not here.
  assign unused_sink = cca_all_pages_h;

  assign grants      = {wb_grant_h, cca_grant_h, chan_grant_h, ebox_grant_h};
  assign any_grant   = |grants;
  assign multi_grant = |(grants & (grants - GW'(1)));
  assign vpage       = vma_h[OFF_W +: OFF_W];
  assign refill_off  = vpage >> 1;
  assign cyc_type_h  = 3'(state);

  // Lowest-numbered granted channel wins.
  always_comb begin
    chan_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (chan_grant_h[i]) chan_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_nxt    = state;
    pa_nxt       = pa_h;
    chan_sel_nxt = chan_sel_h;
    cca_cnt_nxt  = cca_cnt;
    cry_nxt      = 1'b0;
    err_nxt      = 1'b0;
    if (!hold_h) begin
      case (state)
        ST_IDLE: begin
          if (csh_ready_to_go_h && any_grant) begin
            err_nxt = multi_grant;
            if (wb_grant_h) begin
              state_nxt = ST_WB;
              pa_nxt    = {cam_page_h, vma_h[OFF_W-1:0]};
            end else if (cca_grant_h) begin
              state_nxt = ST_CCA;
              pa_nxt    = {cam_page_h, cca_cnt, 2'b00};
            end else if (|chan_grant_h) begin
              state_nxt    = ST_CHAN;
              chan_sel_nxt = chan_idx;
              pa_nxt       = ccw_adr_h[chan_idx*PA_W +: PA_W];
            end else begin
              state_nxt = ST_EBOX;
              pa_nxt    = ebox_paged_h ? {pt_frame_h, vma_h[OFF_W-1:0]} : vma_h;
            end
          end
        end
        ST_EBOX: begin
          if (cyc_done_h) begin
            state_nxt = ST_IDLE;
          end else if (page_refill_h) begin
            state_nxt = ST_REFILL;
            pa_nxt    = {(vma_user_h ? ubr : ebr), refill_off};
          end
        end
        ST_CCA: begin
          if (cyc_done_h) begin
            state_nxt   = ST_IDLE;
            cca_cnt_nxt = cca_cnt + CCA_W'(1);
            cry_nxt     = &cca_cnt;
          end
        end
        default: begin
          if (cyc_done_h) state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Cycle state, address and status pulses; parity tracks every address update.
  always_ff @(posedge clk_pma_h or posedge mr_reset_h) begin
    if (mr_reset_h) begin
      state         <= ST_IDLE;
      pa_h          <= '0;
      pa_par_h      <= 1'b1;
      chan_sel_h    <= '0;
      cca_cnt       <= '0;
      cca_cry_out_h <= 1'b0;
      grant_err_h   <= 1'b0;
    end else begin
      state         <= state_nxt;
      pa_h          <= pa_nxt;
      pa_par_h      <= ~^pa_nxt;
      chan_sel_h    <= chan_sel_nxt;
      cca_cnt       <= cca_cnt_nxt;
      cca_cry_out_h <= cry_nxt;
      grant_err_h   <= err_nxt;
    end
  end

  // Page-table base registers load regardless of cycle state or hold.
  always_ff @(posedge clk_pma_h or posedge mr_reset_h) begin
    if (mr_reset_h) begin
      ebr <= '0;
      ubr <= '0;
    end else begin
      if (load_ebr_h) ebr <= base_in;
      if (load_ubr_h) ubr <= base_in;
    end
  end

endmodule

// File: tb/tb_pma_xlat.sv
// Directed self-checking bench for pma_xlat at default parameters.
module tb_pma_xlat;
  localparam int PAGE_W = 13;
  localparam int OFF_W  = 9;
  localparam int NCHAN  = 4;
  localparam int PA_W   = PAGE_W + OFF_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ready, ebox_grant, cca_grant, wb_grant;
  logic [NCHAN-1:0]      chan_grant;
  logic                  done, hold, refill, paged, user, load_ebr, load_ubr;
  logic [PAGE_W-1:0]     base, pt_frame, cam_page;
  logic [PA_W-1:0]       vma;
  logic [NCHAN*PA_W-1:0] ccw;
  logic                  all_pages;
  logic [PA_W-1:0]       pa_h;
  logic                  pa_par_h;
  logic [2:0]            cyc_type_h;
  logic [1:0]            chan_sel_h;
  logic                  cca_cry_out_h, grant_err_h;

  int compared   = 0;
  int mismatched = 0;
  int cry_count  = 0;

  always #5 clk = ~clk;

  pma_xlat dut (
    .clk_pma_h(clk), .mr_reset_h(rst), .csh_ready_to_go_h(ready),
    .ebox_grant_h(ebox_grant), .chan_grant_h(chan_grant), .cca_grant_h(cca_grant),
    .wb_grant_h(wb_grant), .cyc_done_h(done), .hold_h(hold), .page_refill_h(refill),
    .ebox_paged_h(paged), .vma_user_h(user), .load_ebr_h(load_ebr), .load_ubr_h(load_ubr),
    .base_in(base), .vma_h(vma), .pt_frame_h(pt_frame), .ccw_adr_h(ccw),
    .cam_page_h(cam_page), .cca_all_pages_h(all_pages), .pa_h(pa_h), .pa_par_h(pa_par_h),
    .cyc_type_h(cyc_type_h), .chan_sel_h(chan_sel_h), .cca_cry_out_h(cca_cry_out_h),
    .grant_err_h(grant_err_h)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pa(input string tag, input logic [PA_W-1:0] exp);
    check_output(tag, 32'(pa_h), 32'(exp));
    check_output({tag, "_par"}, 32'(pa_par_h), 32'(~^exp));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ready = 0; ebox_grant = 0; cca_grant = 0; wb_grant = 0; chan_grant = '0;
    done = 0; hold = 0; refill = 0; paged = 0; user = 0; load_ebr = 0; load_ubr = 0;
    base = '0; pt_frame = '0; cam_page = '0; vma = '0; all_pages = 0;
    ccw = {22'h0C0C0, 22'h3F000, 22'h2AAAA, 22'h11111};
    repeat (2) tick;
    rst = 1'b0;
    check_pa("rst_pa", 22'h0);
    check_output("rst_type", 32'(cyc_type_h), 0);
    check_output("rst_sel", 32'(chan_sel_h), 0);
    check_output("rst_cry", 32'(cca_cry_out_h), 0);
    check_output("rst_err", 32'(grant_err_h), 0);

    // Unpaged EBOX, also load EBR while idle
    ready = 1; ebox_grant = 1; vma = 22'h12345; load_ebr = 1; base = 13'h0AAA;
    tick;
    ebox_grant = 0; load_ebr = 0;
    check_pa("ebox_pa", 22'h12345);
    check_output("ebox_type", 32'(cyc_type_h), 1);
    check_output("ebox_err", 32'(grant_err_h), 0);
    done = 1; tick; done = 0;
    check_output("done_type", 32'(cyc_type_h), 0);
    check_pa("done_pa_kept", 22'h12345);

    // Paged EBOX then user refill
    ebox_grant = 1; paged = 1; pt_frame = 13'h0ABC; vma = 22'h1FDF7;
    load_ubr = 1; base = 13'h0100;
    tick;
    ebox_grant = 0; load_ubr = 0;
    check_pa("paged_pa", {13'h0ABC, 9'h1F7});
    refill = 1; user = 1;
    tick;
    refill = 0;
    check_output("refill_type", 32'(cyc_type_h), 5);
    check_pa("refill_ubr_pa", {13'h0100, 9'h07F});

    // Async reset mid-REFILL
    #2 rst = 1'b1;
    #1;
    check_output("arst_type", 32'(cyc_type_h), 0);
    check_pa("arst_pa", 22'h0);
    tick;
    rst = 1'b0;
    ebox_grant = 1; paged = 0;
    tick;
    ebox_grant = 0;
    refill = 1; user = 1;
    tick;
    refill = 0;
    check_pa("ubr_cleared_pa", 22'h0007F);
    done = 1; tick; done = 0;

    // Channel cycles
    chan_grant = 4'b0100;
    tick;
    chan_grant = '0;
    check_pa("chan2_pa", 22'h3F000);
    check_output("chan2_sel", 32'(chan_sel_h), 2);
    check_output("chan2_type", 32'(cyc_type_h), 2);
    check_output("chan2_err", 32'(grant_err_h), 0);
    done = 1; tick; done = 0;
    chan_grant = 4'b0110;
    tick;
    chan_grant = '0;
    check_pa("chan1_pa", 22'h2AAAA);
    check_output("chan1_sel", 32'(chan_sel_h), 1);
    check_output("chan1_err", 32'(grant_err_h), 1);
    tick;
    check_output("err_pulse_end", 32'(grant_err_h), 0);

    // Grant alongside done is deferred one cycle
    done = 1; ebox_grant = 1; vma = 22'h00321;
    tick;
    done = 0;
    check_output("defer_type", 32'(cyc_type_h), 0);
    tick;
    ebox_grant = 0;
    check_output("defer_accept_type", 32'(cyc_type_h), 1);
    check_pa("defer_pa", 22'h00321);
    done = 1; tick; done = 0;

    // Full sweep of the cache-line counter
    cam_page = '0;
    for (int i = 0; i < 128; i++) begin
      cca_grant = 1; tick; cca_grant = 0;
      check_pa("cca_pa", 22'(i * 4));
      done = 1; tick; done = 0;
      check_output("cca_cry", 32'(cca_cry_out_h), (i == 127) ? 1 : 0);
      cry_count += int'(cca_cry_out_h);
    end
    check_pa("cca_last_pa", 22'h001FC);
    check_output("cry_count", cry_count, 1);
    cam_page = 13'h0005; cca_grant = 1;
    tick;
    cca_grant = 0;
    check_pa("cca_wrapped_pa", 22'h00A00);
    check_output("cry_cleared", 32'(cca_cry_out_h), 0);
    done = 1; tick; done = 0;

    // WB wins over CCA and EBOX
    cam_page = 13'h0123; vma = 22'h001F7;
    wb_grant = 1; cca_grant = 1; ebox_grant = 1;
    tick;
    wb_grant = 0; cca_grant = 0; ebox_grant = 0;
    check_output("wb_type", 32'(cyc_type_h), 4);
    check_output("wb_err", 32'(grant_err_h), 1);
    check_pa("wb_pa", {13'h0123, 9'h1F7});

    // Hold freezes the cycle even with done asserted
    hold = 1; done = 1;
    tick;
    check_output("hold_type1", 32'(cyc_type_h), 4);
    tick;
    check_output("hold_type2", 32'(cyc_type_h), 4);
    hold = 0;
    tick;
    done = 0;
    check_output("unhold_type", 32'(cyc_type_h), 0);
    check_pa("unhold_pa", {13'h0123, 9'h1F7});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
